control_fsm: RTL

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/control_fsm_pkg.sv | 60 ++++++
 rtl/mem_wait_timer.sv | 35 +++
 rtl/control_fsm.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/control_fsm_pkg.sv
// Shared encodings for the multi-cycle control FSM: opcodes, states and
// the select codes it drives into the datapath.
package control_fsm_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_ALU   = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_CMP   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    function automatic logic is_legal(input logic [4:0] op);
        case (op)
            OP_R, OP_IMM, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_JALR, OP_LUI, OP_JAL: is_legal = 1'b1;
            default:                            is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] imm_sel(input logic [4:0] op);
        case (op)
            OP_STORE:  imm_sel = IMM_S;
            OP_BRANCH: imm_sel = IMM_B;
            OP_LUI:    imm_sel = IMM_U;
            OP_JAL:    imm_sel = IMM_J;
            default:   imm_sel = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts unanswered memory-request cycles; saturates and flags expiry at
// MEM_TIMEOUT.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 255,
    localparam int unsigned W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic count_i,
    input  logic clear_i,
    output logic expired_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q == W'(MEM_TIMEOUT));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory access
// and write-back strobes, with a sticky trap on illegal opcodes or memory hangs.
//
//   state  | meaning
//   FETCH  | request instruction word, load IR on ready
//   DECODE | opcode legality check
//   EXEC   | ALU operation; branches resolve here
//   MEM    | data load/store request held until ready
//   WB     | register write and PC update
//   TRAP   | fault, left only by reset
module control_fsm
    import control_fsm_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [4:0] Opcode_i,
    input  logic       Zero_i,
    input  logic       MemReady_i,
    output logic       MemReq_o,
    output logic       MemWrite_o,
    output logic       IRWrite_o,
    output logic       PCWrite_o,
    output logic [1:0] PCSrc_o,
    output logic       ALUSrcB_o,
    output logic [1:0] ALUOp_o,
    output logic       RegWrite_o,
    output logic [1:0] WBSel_o,
    output logic [2:0] ImmSel_o,
    output logic       Trap_o,
    output logic [2:0] State_o
);

    state_e state_q, state_d;
    logic   run_q, run_d;
    logic   expired;
    logic   timer_clr;

    // run_q holds every strobe low until the first edge after reset release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_FETCH;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        run_d      = 1'b1;
        state_d    = state_q;
        MemReq_o   = 1'b0;
        MemWrite_o = 1'b0;
        IRWrite_o  = 1'b0;
        PCWrite_o  = 1'b0;
        PCSrc_o    = PC_PLUS4;
        ALUSrcB_o  = 1'b0;
        ALUOp_o    = ALU_ADD;
        RegWrite_o = 1'b0;
        WBSel_o    = WB_ALU;
        Trap_o     = 1'b0;
        if (run_q) begin
            case (state_q)
                ST_FETCH: begin
                    MemReq_o = 1'b1;
                    if (expired) begin
                        state_d = ST_TRAP;
                    end else if (MemReady_i) begin
                        IRWrite_o = 1'b1;
                        state_d   = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    state_d = is_legal(Opcode_i) ? ST_EXEC : ST_TRAP;
                end
                ST_EXEC: begin
                    case (Opcode_i)
                        OP_R, OP_IMM: begin
                            ALUOp_o = ALU_FUNCT;
                            state_d = ST_WB;
                        end
                        OP_LOAD, OP_STORE: begin
                            ALUOp_o   = ALU_ADD;
                            ALUSrcB_o = 1'b1;
                            state_d   = ST_MEM;
                        end
                        OP_BRANCH: begin
                            ALUOp_o   = ALU_CMP;
                            PCWrite_o = 1'b1;
                            PCSrc_o   = Zero_i ? PC_IMM : PC_PLUS4;
                            state_d   = ST_FETCH;
                        end
                        OP_JAL, OP_JALR, OP_LUI: state_d = ST_WB;
                        default:                 state_d = ST_TRAP;
                    endcase
                end
                ST_MEM: begin
                    MemReq_o   = 1'b1;
                    MemWrite_o = (Opcode_i == OP_STORE);
                    if (expired) begin
                        state_d = ST_TRAP;
                    end else if (MemReady_i) begin
                        if (Opcode_i == OP_STORE) begin
                            PCWrite_o = 1'b1;
                            state_d   = ST_FETCH;
                        end else begin
                            state_d = ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    RegWrite_o = 1'b1;
                    PCWrite_o  = 1'b1;
                    state_d    = ST_FETCH;
                    case (Opcode_i)
                        OP_LOAD: WBSel_o = WB_MEM;
                        OP_JAL: begin
                            WBSel_o = WB_PC4;
                            PCSrc_o = PC_IMM;
                        end
                        OP_JALR: begin
                            WBSel_o = WB_PC4;
                            PCSrc_o = PC_ALU;
                        end
                        OP_LUI:  WBSel_o = WB_IMM;
                        default: WBSel_o = WB_ALU;
                    endcase
                end
                ST_TRAP: Trap_o = 1'b1;
                default: state_d = ST_TRAP;
            endcase
        end
    end

    assign timer_clr = MemReady_i || (state_d != state_q);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .count_i  (MemReq_o && !MemReady_i),
        .clear_i  (timer_clr),
        .expired_o(expired)
    );

    assign ImmSel_o = imm_sel(Opcode_i);
    assign State_o  = state_q;

endmodule
